// File: rtl/bias_stream_pkg.sv
// bias_stream_pkg: shared state encoding and credit sizing for the bias ROM streamer
package bias_stream_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_e;
  function automatic int credit_w(input int buf_depth, input int rom_latency);
    return $clog2(buf_depth + rom_latency + 1) + 1;
  endfunction
endpackage

// File: rtl/bias_stream_fifo.sv
// bias_stream_fifo: show-ahead FIFO re-aligning fixed-latency ROM returns to the output stream
module bias_stream_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int BUF_DEPTH = 4,
  localparam int CNT_W = $clog2(BUF_DEPTH + 1),
  localparam int PTR_W = BUF_DEPTH > 1 ? $clog2(BUF_DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  empty,
  output logic [CNT_W-1:0]      count
);
  logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic do_pop;
  always_comb begin
    do_pop = pop && cnt_q != '0;
    wr_d = push ? (wr_q == PTR_W'(BUF_DEPTH - 1) ? '0 : wr_q + PTR_W'(1)) : wr_q;
    rd_d = do_pop ? (rd_q == PTR_W'(BUF_DEPTH - 1) ? '0 : rd_q + PTR_W'(1)) : rd_q;
    cnt_d = cnt_q + CNT_W'(push) - CNT_W'(do_pop);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  always_ff @(posedge clk)
    if (push) mem_q[wr_q] <= din;
  assign empty = cnt_q == '0;
  assign count = cnt_q;
  assign dout = empty ? '0 : mem_q[rd_q];
  // credit-based issue makes this unreachable; flag it loudly if it ever happens
  always_ff @(posedge clk)
    if (!rst) assert (!(push && !do_pop && cnt_q == CNT_W'(BUF_DEPTH))) else $error("bias_stream_fifo overflow");
endmodule

// File: rtl/bias_rom_stream_ctrl.sv
// bias_rom_stream_ctrl: credit-paced ROM reader turning a fixed-latency ROM into a valid/ready bias stream
module bias_rom_stream_ctrl import bias_stream_pkg::*; #(
  parameter int DATA_WIDTH = 16,
  parameter int OUT_DEPTH = 32,
  parameter int ROM_LATENCY = 2,
  parameter int REPEAT = 1,
  parameter int BUF_DEPTH = ROM_LATENCY + 2,
  parameter int ADDR_WIDTH = $clog2(OUT_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic                  rom_ce,
  input  logic [DATA_WIDTH-1:0] rom_q,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_out_valid,
  input  logic                  data_out_ready
);
  localparam int CW = credit_w(BUF_DEPTH, ROM_LATENCY);
  localparam int PW = REPEAT > 1 ? $clog2(REPEAT) : 1;
  localparam int FCW = $clog2(BUF_DEPTH + 1);
  state_e state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [PW-1:0] pass_q, pass_d;
  logic [ROM_LATENCY-1:0] track_q, track_d;
  logic [FCW-1:0] fifo_count;
  logic [CW-1:0] in_flight, credit;
  logic fifo_empty, pop, issue, last_addr, last_pass;
  always_comb begin
    in_flight = '0;
    for (int i = 0; i < ROM_LATENCY; i++) in_flight = in_flight + CW'(track_q[i]);
    pop = !fifo_empty && data_out_ready;
    credit = in_flight + CW'(fifo_count) - CW'(pop);
    issue = state_q == RUN && credit < CW'(BUF_DEPTH);
    last_addr = addr_q == ADDR_WIDTH'(OUT_DEPTH - 1);
    last_pass = pass_q == PW'(REPEAT - 1);
    done = state_q == DRAIN && pop && fifo_count == FCW'(1) && track_q == '0;
    addr_d = issue ? (last_addr ? '0 : addr_q + ADDR_WIDTH'(1)) : addr_q;
    pass_d = issue && last_addr ? (last_pass ? '0 : pass_q + PW'(1)) : pass_q;
    track_d = ROM_LATENCY'({track_q, issue});
    state_d = state_q == IDLE && start ? RUN :
              issue && last_addr && last_pass ? DRAIN :
              done ? IDLE : state_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      pass_q <= '0;
      track_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      pass_q <= pass_d;
      track_q <= track_d;
    end
  assign busy = state_q != IDLE;
  assign rom_ce = busy;
  assign rom_addr = addr_q;
  assign data_out_valid = !fifo_empty;
  bias_stream_fifo #(.DATA_WIDTH(DATA_WIDTH), .BUF_DEPTH(BUF_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(track_q[ROM_LATENCY-1]),
    .pop(pop),
    .din(rom_q),
    .dout(data_out),
    .empty(fifo_empty),
    .count(fifo_count)
  );
endmodule
